// File: rtl/mux4_arbiter_if.sv
// Request/grant bundle between the four requesters and the shared-mux arbiter.
interface mux4_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] hold_cnt;

    // Arbiter side: consumes requests, produces grant and mux select.
    modport master (
        input  req,
        output gnt, sel, busy, hold_cnt
    );

    // Requester side: raises requests, observes grant and select.
    modport slave (
        output req,
        input  gnt, sel, busy, hold_cnt
    );
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux. Grants one requester at a time
// for at most MAX_HOLD cycles and drives the registered mux select.
module mux4_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           reset,
    mux4_arbiter_if.master bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [1:0] pick_ptr;
    logic [1:0] pick_next;
    logic [1:0] owner_inc;
    logic       keep;

    // First requesting index at or after start, wrapping mod 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        // Scan from the far end back so the nearest hit overwrites the rest.
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        onehot = 4'b0001 << i;
    endfunction

    assign owner_inc = owner + 2'd1;
    assign pick_ptr  = pick(bus.req, ptr);
    // Successor search starts after the owner, so the owner is considered last.
    assign pick_next = pick(bus.req, owner_inc);
    assign keep      = bus.req[owner] && (bus.hold_cnt < 4'(MAX_HOLD));

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= 2'd0;
            ptr          <= 2'd0;
            bus.gnt      <= 4'b0000;
            bus.sel      <= 2'd0;
            bus.busy     <= 1'b0;
            bus.hold_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state        <= GRANT;
                        owner        <= pick_ptr;
                        bus.gnt      <= onehot(pick_ptr);
                        bus.sel      <= pick_ptr;
                        bus.busy     <= 1'b1;
                        bus.hold_cnt <= 4'd1;
                    end
                end
                GRANT: begin
                    if (keep) begin
                        bus.hold_cnt <= bus.hold_cnt + 4'd1;
                    end else begin
                        ptr <= owner_inc;
                        if (|bus.req) begin
                            // Hand over on the same edge; no idle bubble.
                            owner        <= pick_next;
                            bus.gnt      <= onehot(pick_next);
                            bus.sel      <= pick_next;
                            bus.hold_cnt <= 4'd1;
                        end else begin
                            // sel keeps the last owner while idle.
                            state        <= IDLE;
                            bus.gnt      <= 4'b0000;
                            bus.busy     <= 1'b0;
                            bus.hold_cnt <= 4'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter: one instance with MAX_HOLD=4, one with 1.
module tb_mux4_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mux4_arbiter_if bus0 ();
    mux4_arbiter_if bus1 ();

    mux4_arbiter #(.MAX_HOLD(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mux4_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus0.req = 4'b0000;
        bus1.req = 4'b0000;
        reset    = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] eg;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus0.req = 4'b0000;
        bus1.req = 4'b0000;

        // Reset state
        do_reset();
        chk("rst_gnt",  8'(bus0.gnt), 8'h0);
        chk("rst_sel",  8'(bus0.sel), 8'h0);
        chk("rst_busy", 8'(bus0.busy), 8'h0);
        chk("rst_hold", 8'(bus0.hold_cnt), 8'h0);

        // Single requester: fresh tenure each time MAX_HOLD is reached
        bus0.req = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("single_gnt",  8'(bus0.gnt), 8'h02);
            chk("single_sel",  8'(bus0.sel), 8'h01);
            chk("single_hold", 8'(bus0.hold_cnt), 8'((i % 4) + 1));
        end
        bus0.req = 4'b0000;
        step();
        chk("single_idle_gnt", 8'(bus0.gnt), 8'h0);
        chk("single_idle_sel", 8'(bus0.sel), 8'h01);

        // Full contention: 0,1,2,3,0 for 4 cycles each
        do_reset();
        bus0.req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                eg = 4'b0001 << (o % 4);
                chk("rot_gnt",  8'(bus0.gnt), 8'(eg));
                chk("rot_sel",  8'(bus0.sel), 8'(o % 4));
                chk("rot_hold", 8'(bus0.hold_cnt), 8'(c + 1));
                chk("rot_busy", 8'(bus0.busy), 8'h1);
            end
        end

        // Early release with skip of idle indices 1 and 2
        do_reset();
        bus0.req = 4'b1001;
        step();
        chk("early_gnt0", 8'(bus0.gnt), 8'h01);
        step();
        chk("early_hold2", 8'(bus0.hold_cnt), 8'h02);
        bus0.req = 4'b1000;
        step();
        chk("early_gnt3", 8'(bus0.gnt), 8'h08);
        chk("early_sel3", 8'(bus0.sel), 8'h03);
        chk("early_hold", 8'(bus0.hold_cnt), 8'h01);

        // Idle return, then pointer resumes after the last owner
        do_reset();
        bus0.req = 4'b0100;
        step();
        chk("idle_gnt2", 8'(bus0.gnt), 8'h04);
        step();
        bus0.req = 4'b0000;
        step();
        chk("idle_gnt",  8'(bus0.gnt), 8'h0);
        chk("idle_busy", 8'(bus0.busy), 8'h0);
        chk("idle_hold", 8'(bus0.hold_cnt), 8'h0);
        chk("idle_sel",  8'(bus0.sel), 8'h02);
        bus0.req = 4'b0101;
        step();
        chk("wrap_gnt0", 8'(bus0.gnt), 8'h01);
        chk("wrap_sel0", 8'(bus0.sel), 8'h00);

        // Asynchronous reset mid-tenure
        do_reset();
        bus0.req = 4'b0100;
        step();
        chk("arst_pre_gnt", 8'(bus0.gnt), 8'h04);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_gnt",  8'(bus0.gnt), 8'h0);
        chk("arst_sel",  8'(bus0.sel), 8'h0);
        chk("arst_busy", 8'(bus0.busy), 8'h0);
        chk("arst_hold", 8'(bus0.hold_cnt), 8'h0);
        bus0.req = 4'b1000;
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("arst_post_gnt", 8'(bus0.gnt), 8'h08);
        chk("arst_post_sel", 8'(bus0.sel), 8'h03);

        // MAX_HOLD = 1: rotate every cycle
        do_reset();
        bus1.req = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            step();
            eg = (i % 2 == 0) ? 4'b0010 : 4'b0100;
            chk("mh1_gnt",  8'(bus1.gnt), 8'(eg));
            chk("mh1_hold", 8'(bus1.hold_cnt), 8'h01);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter and sequencer for the shared 4:1 single-bit multiplexer. Four requesters compete for the multiplexer output. The arbiter grants one requester at a time, holds that grant for a bounded tenure, and drives the registered 2-bit select `sel` into the multiplexer's `s` input. It also returns a one-hot grant to the requesters so each knows when its bit is on the shared output.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one requester may hold the grant. Legal range is 1..15.
- `clk`  input  1  — single clock; everything is sampled on the rising edge.
- `reset`  input  1  — asynchronous, active-high reset.
- `req`  input  4  — request lines; `req[i]` belongs to requester i, which is mux input `a[i]`. Level-sensitive.
- `gnt`  output  4  — registered one-hot grant, or all-zero when idle.
- `sel`  output  2  — registered binary index of the current owner. Connects to mux `s[1:0]`.
- `busy`  output  1  — registered; 1 whenever `gnt` is nonzero.
- `hold_cnt`  output  4  — registered count of cycles the current owner has held the grant. 0 when idle.

## Operation
- **State.**
  - `state` is IDLE or GRANT.
  - `owner[1:0]` is the current grant holder.
  - `ptr[1:0]` is the highest-priority index for the next arbitration.
  - `hold_cnt` counts tenure cycles.
- **Reset.** While `reset` is high, asynchronously:
  - `state` = IDLE, `ptr` = 0, `owner` = 0.
  - `gnt` = 4'b0000, `sel` = 2'b00, `busy` = 0, `hold_cnt` = 0.
  - Reset mid-tenure drops the grant immediately, with no completion cycle.
- **Arbitration function `pick(start)`.** Scan indices start, start+1, start+2, start+3, wrapping mod 4. Return the first i with `req[i]` = 1.
- **IDLE.**
  - If `req` = 0, stay in IDLE. Outputs hold, except that `sel` keeps its last value.
  - If `req` ≠ 0, then on the next edge: `owner` = `pick(ptr)`, `gnt` = one-hot(owner), `sel` = owner, `busy` = 1, `hold_cnt` = 1, and go to GRANT.
- **GRANT continues** when `req[owner]` = 1 and `hold_cnt` < `MAX_HOLD`. Grant is unchanged and `hold_cnt` increments.
- **GRANT releases** when `req[owner]` = 0 or `hold_cnt` = `MAX_HOLD`. On release:
  - `ptr` = owner+1 mod 4.
  - If any `req` bit is set, `pick(owner+1)` is granted on the same edge. There is no idle bubble and `hold_cnt` = 1.
  - The just-released owner is considered last. It is re-granted only if it is the sole requester, which starts a fresh tenure.
  - If `req` = 0, go to IDLE with `gnt` = 0, `busy` = 0, `hold_cnt` = 0. `sel` holds the last owner.
- **Invariants.**
  - `gnt` is always zero or one-hot.
  - When `busy` = 1, `gnt[sel]` = 1.
  - `hold_cnt` never exceeds `MAX_HOLD`.
- **Requester side.** A requester de-asserting `req` while not granted is simply not considered. No request is latched.

## Timing
- Every output is a flop; there is no combinational path from `req` to any output.
- **Grant latency.** `req` rises before edge k with the arbiter idle, so `gnt`/`sel` are valid after edge k. That is 1 cycle.
- **Release latency.** Owner's `req` is low at edge k, so its grant is gone after edge k. The successor's grant appears after the same edge.
- **Tenure bound.** A continuously requesting owner, with others waiting, holds the grant for exactly `MAX_HOLD` cycles.
- **Worst-case wait.** A requester waits at most 3×`MAX_HOLD` cycles after its `req` rises before it is granted.
- **`MAX_HOLD` = 1.** Grant rotates every cycle among the active requesters.
- **Shared mux.** The mux output reflects `a[sel]` in the same cycle that `gnt` is valid, because the mux path is purely combinational.

## Test plan
- **Reset.** Assert `reset` mid-cycle while `gnt` = 4'b0100. Required: `gnt` = 0, `sel` = 0, `busy` = 0, `hold_cnt` = 0 immediately, before the next edge. After release with `req` = 4'b1000, `gnt` = 4'b1000 one edge later.
- **Single requester.** `req` = 4'b0010 held for 10 cycles, `MAX_HOLD` = 4. Required:
  - `gnt` = 4'b0010 continuously, `sel` = 1.
  - `hold_cnt` runs 1,2,3,4,1,2,3,4,1,2, with a fresh tenure at each wrap.
- **Full contention rotation.** `req` = 4'b1111 from reset, `MAX_HOLD` = 4. Required: grants go 0,1,2,3,0, each for exactly 4 cycles. `sel` tracks the owner, with no idle cycles.
- **Early release and skip.** Owner 0 drops `req` after 2 cycles while `req` = 4'b1001. Required: next edge `gnt` = 4'b1000, `sel` = 3. Index 1 and index 2 are skipped.
- **Idle return.** The only requester, 2, drops `req`. Required: after the next edge `gnt` = 0, `busy` = 0, `hold_cnt` = 0, `sel` stays 2. New `req` = 4'b0101 gives a grant to 3→wrap→0, because `ptr` = 3.
- **`MAX_HOLD` = 1.** `req` = 4'b0110. Required: `gnt` alternates 4'b0010, 4'b0100 every cycle and `hold_cnt` stays 1.
